// File: rtl/ins_load_pkg.sv
// Shared sizing defaults, loader state type and the constant init image for ins_load_for_ram.
package ins_load_pkg;

  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_DEPTH  = 32;

  typedef enum logic {
    ST_LOAD,
    ST_DONE
  } load_state_e;

  typedef logic [DEF_DEPTH-1:0][DEF_DATA_W-1:0] image_t;

  // Entry i holds 0xA0 + i.
  function automatic image_t build_image();
    image_t img;
    for (int unsigned i = 0; i < DEF_DEPTH; i++) begin
      img[i] = DEF_DATA_W'(32'hA0 + i);
    end
    return img;
  endfunction

  localparam image_t INIT_IMAGE = build_image();

endpackage

// File: rtl/ins_load_for_ram_if.sv
// Loader/read-port signal bundle between ins_load_for_ram and its user.
interface ins_load_for_ram_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
) ();

  logic              WE;
  logic [ADDR_W-1:0] RdAddr;
  logic [ADDR_W-1:0] RamAddressInit;
  logic [DATA_W-1:0] RamDInit;
  logic [DATA_W-1:0] Q;
  logic              Done;

  modport master (
    output WE, RdAddr,
    input  RamAddressInit, RamDInit, Q, Done
  );

  modport slave (
    input  WE, RdAddr,
    output RamAddressInit, RamDInit, Q, Done
  );

endinterface

// File: rtl/ins_load_for_ram_ram.sv
// Single-port synchronous RAM, read-before-write, no reset on storage or output.
module ram_memory #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 32
) (
  input  logic              Clock,
  input  logic              WE,
  input  logic [DATA_W-1:0] D,
  input  logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] Q
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Q samples the array before this edge's write lands, so collisions return old data.
  always_ff @(posedge Clock) begin
    if (WE) begin
      mem[Address] <= D;
    end
    Q <= mem[Address];
  end

endmodule

// File: rtl/ins_load_for_ram.sv
// Loads the constant init image into a RAM after reset, then serves registered reads on RdAddr.
module ins_load_for_ram
  import ins_load_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic              Clock,
  input  logic              Reset,
  ins_load_for_ram_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  load_state_e       state;
  load_state_e       state_next;
  logic [ADDR_W-1:0] load_addr;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_q;
  logic              wr_stb;
  logic              ram_we;
  logic              q_zero;

  always_comb begin
    state_next = state;
    wr_stb     = bus.WE && (state == ST_LOAD);
    ram_we     = wr_stb && Reset;
    if (wr_stb && (load_addr == LAST_ADDR)) begin
      state_next = ST_DONE;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state     <= ST_LOAD;
      load_addr <= '0;
    end else begin
      state <= state_next;
      if (wr_stb && (load_addr != LAST_ADDR)) begin
        load_addr <= load_addr + 1'b1;
      end
    end
  end

  // The RAM has no reset; Q is forced to zero for the cycle following a reset edge instead.
  always_ff @(posedge Clock) begin
    q_zero <= !Reset;
  end

  assign ram_addr           = (state == ST_DONE) ? bus.RdAddr : load_addr;
  assign bus.RamAddressInit = load_addr;
  assign bus.RamDInit       = DATA_W'(INIT_IMAGE[load_addr]);
  assign bus.Done           = (state == ST_DONE);
  assign bus.Q              = q_zero ? '0 : ram_q;

  ram_memory #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .Clock  (Clock),
    .WE     (ram_we),
    .D      (bus.RamDInit),
    .Address(ram_addr),
    .Q      (ram_q)
  );

endmodule

// File: tb/tb_ins_load_for_ram.sv
// Directed bench for ins_load_for_ram with a cycle-level reference model of the loader and RAM.
module tb_ins_load_for_ram;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ins_load_for_ram_if #(.ADDR_W(5), .DATA_W(8)) bus ();

  ins_load_for_ram #(.ADDR_W(5), .DATA_W(8), .DEPTH(32)) dut (
    .Clock(clk),
    .Reset(rst_n),
    .bus  (bus)
  );

  // Reference model state
  logic [7:0] m_mem   [32];
  bit         m_known [32];
  int         m_addr  = 0;
  bit         m_done  = 0;
  logic [7:0] m_q     = '0;
  bit         m_qk    = 0;
  bit         m_live  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_known[i] = 0;
  end

  always @(posedge clk) begin
    int         ra;
    logic [7:0] rv;
    bit         rk;
    if (!rst_n) begin
      m_addr = 0;
      m_done = 0;
      m_q    = 8'h00;
      m_qk   = 1;
      m_live = 1;
    end else if (m_live) begin
      ra = m_done ? int'(bus.RdAddr) : m_addr;
      rv = m_mem[ra];
      rk = m_known[ra];
      if (bus.WE && !m_done) begin
        m_mem[m_addr]   = 8'(8'hA0 + m_addr);
        m_known[m_addr] = 1;
        if (m_addr == 31) m_done = 1;
        else m_addr = m_addr + 1;
      end
      m_q  = rv;
      m_qk = rk;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("addr", 32'(bus.RamAddressInit), 32'(m_addr));
      chk("dinit", 32'(bus.RamDInit), 32'(8'(8'hA0 + m_addr)));
      chk("done", 32'(bus.Done), 32'(m_done));
      if (m_qk) chk("q", 32'(bus.Q), 32'(m_q));
    end
  end

  task automatic tick(input logic we, input logic [4:0] rd, input logic rst);
    bus.WE     = we;
    bus.RdAddr = rd;
    rst_n      = rst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.WE     = 1'b0;
    bus.RdAddr = '0;
    rst_n      = 1'b0;

    // Reset state
    tick(1'b0, 5'd0, 1'b0);
    chk("rst_addr", 32'(bus.RamAddressInit), 32'd0);
    chk("rst_done", 32'(bus.Done), 32'd0);
    chk("rst_q", 32'(bus.Q), 32'd0);
    chk("rst_dinit", 32'(bus.RamDInit), 32'hA0);

    // Load with a 3-cycle stall at address 10
    for (int k = 0; k < 10; k++) tick(1'b1, 5'd0, 1'b1);
    chk("pre_stall_addr", 32'(bus.RamAddressInit), 32'd10);
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 5'd0, 1'b1);
      chk("stall_addr", 32'(bus.RamAddressInit), 32'd10);
      chk("stall_dinit", 32'(bus.RamDInit), 32'hAA);
    end
    for (int k = 0; k < 21; k++) tick(1'b1, 5'd0, 1'b1);
    chk("last_addr", 32'(bus.RamAddressInit), 32'd31);
    chk("not_done_yet", 32'(bus.Done), 32'd0);
    tick(1'b1, 5'd0, 1'b1);
    chk("done_set", 32'(bus.Done), 32'd1);
    chk("done_addr_hold", 32'(bus.RamAddressInit), 32'd31);
    tick(1'b1, 5'd0, 1'b1);
    chk("no_wrap", 32'(bus.RamAddressInit), 32'd31);

    // Read sweep with WE held high
    for (int r = 0; r < 32; r++) begin
      tick(1'b1, 5'(r), 1'b1);
      chk("sweep_q", 32'(bus.Q), 32'(8'hA0 + r));
    end

    // Reset mid-load at 17; also stale value in mem[17] must survive the reset edge
    tick(1'b0, 5'd0, 1'b0);
    for (int k = 0; k < 17; k++) tick(1'b1, 5'd0, 1'b1);
    chk("mid_addr", 32'(bus.RamAddressInit), 32'd17);
    dut.u_ram.mem[17] = 8'h22;
    m_mem[17]         = 8'h22;
    tick(1'b1, 5'd0, 1'b0);
    chk("abort_addr", 32'(bus.RamAddressInit), 32'd0);
    chk("abort_done", 32'(bus.Done), 32'd0);
    chk("abort_q", 32'(bus.Q), 32'd0);
    for (int k = 0; k < 18; k++) tick(1'b1, 5'd0, 1'b1);
    chk("old_17", 32'(bus.Q), 32'h22);
    for (int k = 18; k < 32; k++) tick(1'b1, 5'd0, 1'b1);
    chk("reload_done", 32'(bus.Done), 32'd1);
    tick(1'b1, 5'd17, 1'b1);
    chk("new_17", 32'(bus.Q), 32'hB1);

    // Reset after Done keeps RAM contents
    tick(1'b0, 5'd0, 1'b0);
    tick(1'b0, 5'd0, 1'b1);
    chk("kept_0", 32'(bus.Q), 32'hA0);

    // Collision: mem[5] preloaded, loader reads old and writes image word on same edge
    dut.u_ram.mem[5] = 8'h11;
    m_mem[5]         = 8'h11;
    for (int k = 0; k < 6; k++) tick(1'b1, 5'd0, 1'b1);
    chk("coll_old", 32'(bus.Q), 32'h11);
    for (int k = 6; k < 32; k++) tick(1'b1, 5'd0, 1'b1);
    chk("coll_done", 32'(bus.Done), 32'd1);
    tick(1'b1, 5'd5, 1'b1);
    chk("coll_new", 32'(bus.Q), 32'hA5);
    tick(1'b0, 5'd31, 1'b1);
    chk("read_31", 32'(bus.Q), 32'hBF);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/ins_load_for_ram.md
INS_LOAD_FOR_RAM -- requirements
Module: ins_load_for_ram

Interface
REQ-001 Parameter ADDR_W, default 5, RAM address width.
REQ-002 Parameter DATA_W, default 8, RAM word width.
REQ-003 Parameter DEPTH, default 32 (2**ADDR_W), number of RAM words.
REQ-004 Clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 Reset  in  1  synchronous, active-low reset.
REQ-006 WE  in  1  load write enable; loader writes and advances only while 1.
REQ-007 RdAddr  in  ADDR_W  read address, used once loading is done.
REQ-008 RamAddressInit  out  ADDR_W  current loader address.
REQ-009 RamDInit  out  DATA_W  init-image word for RamAddressInit.
REQ-010 Q  out  DATA_W  registered RAM read data.
REQ-011 Done  out  1  high once all DEPTH words are written.

Function
REQ-012 Init image SHALL be a DEPTH-entry constant table; default entry i = 0xA0 + i (0xA0..0xBF).
REQ-013 RamDInit SHALL always equal INIT_IMAGE[RamAddressInit] (combinational).
REQ-014 Write strobe SHALL be WE AND NOT Done; when 1, the RAM SHALL store RamDInit at RamAddressInit on the rising edge.
REQ-015 On each edge with the write strobe at 1 and RamAddressInit < DEPTH-1, RamAddressInit SHALL increment by 1.
REQ-016 On an edge with the write strobe at 1 and RamAddressInit = DEPTH-1: Done SHALL go to 1 and RamAddressInit SHALL hold at DEPTH-1; no wrap.
REQ-017 With WE = 0 and Done = 0, the loader SHALL stall: no write, address held, no entry skipped.
REQ-018 With Done = 1, WE SHALL be ignored; no further writes SHALL occur.
REQ-019 RAM address SHALL be RamAddressInit while Done = 0, else RdAddr.
REQ-020 Q SHALL be registered with 1-cycle latency: Q(t+1) = mem[addr(t)].
REQ-021 On read/write collision, Q SHALL return the pre-write (old) data.
REQ-022 RAM array SHALL have DEPTH x DATA_W storage, single port, write-first disallowed (per REQ-021).

Reset
REQ-023 Reset = 0 at an edge SHALL set RamAddressInit = 0, Done = 0 and Q = 0; RamDInit then shows 0xA0.
REQ-024 Reset SHALL NOT clear RAM contents; words retain old values until rewritten.
REQ-025 Reset asserted mid-load SHALL abort the load; loading restarts at address 0 once Reset = 1.
REQ-026 No write SHALL occur on an edge where Reset = 0.

Structure
REQ-027 Package ins_load_pkg SHALL hold ADDR_W, DATA_W, DEPTH defaults and the INIT_IMAGE constant table.
REQ-028 The RAM SHALL be the sub-module ram_memory (Clock, WE, D, Address, Q), with no reset, instantiated once; loader counter, Done flag and address mux reside in the top.

Verification
REQ-029 Reset low 1 cycle, then WE = 1 for 32 cycles -> RamAddressInit 0..31, RamDInit 0xA0..0xBF, Done = 1 on the 32nd write edge, address held at 31.
REQ-030 After Done, sweep RdAddr 0..31 -> Q = 0xA0 + RdAddr one cycle later; WE = 1 causes no change.
REQ-031 WE = 0 for 3 cycles at address 10 -> address stays 10, mem[10] written only once WE returns, no skip.
REQ-032 Reset low at address 17 -> next edge address = 0, Done = 0, Q = 0; reload completes in 32 WE cycles.
REQ-033 Preload mem[5] = 0x11, then reload with address 5 read and written on the same edge -> Q = 0x11, next read 0xA5.
REQ-034 After Done, pulse Reset low -> RAM still returns 0xA0 + i for the entries not yet rewritten.
